// File: rtl/death_anim_pkg.sv
// rtl/death_anim_pkg.sv - shared types and constants for the death animation sequencer
package death_anim_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int COORD_W = 10;
  localparam int ADDR_W  = 19;
  localparam int COLOR_W = 24;

  localparam int DEF_SPRITE_W   = 32;
  localparam int DEF_SPRITE_H   = 32;
  localparam int DEF_NUM_FRAMES = 4;
  localparam int DEF_FRAME_HOLD = 6;

  // Word offset between consecutive frames stored back-to-back in frame RAM
  localparam int FRAME_BASE = DEF_SPRITE_W * DEF_SPRITE_H;

  localparam logic [COLOR_W-1:0] DEF_KEY_COLOR = 24'hfffed2;

  // Counter width for a count of n, never narrower than one bit
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/death_anim_sequencer_if.sv
// rtl/death_anim_sequencer_if.sv - video/control bundle between sequencer and its environment
interface death_anim_sequencer_if
  import death_anim_pkg::*;
#(
  parameter int FIDX_W = idx_width(DEF_NUM_FRAMES)
);

  logic               vsync;
  logic               start;
  logic [COORD_W-1:0] DrawX;
  logic [COORD_W-1:0] DrawY;
  logic [COORD_W-1:0] SpriteX;
  logic [COORD_W-1:0] SpriteY;
  logic [COLOR_W-1:0] ram_data;
  logic [ADDR_W-1:0]  read_address;
  logic               sprite_on;
  logic               busy;
  logic               done;
  logic [FIDX_W-1:0]  frame_idx;

  modport master (
    output vsync, start, DrawX, DrawY, SpriteX, SpriteY, ram_data,
    input  read_address, sprite_on, busy, done, frame_idx
  );

  modport slave (
    input  vsync, start, DrawX, DrawY, SpriteX, SpriteY, ram_data,
    output read_address, sprite_on, busy, done, frame_idx
  );

endinterface

// File: rtl/vsync_tick.sv
// rtl/vsync_tick.sv - one-cycle pulse on each falling edge of active-low vsync
module vsync_tick (
  input  logic clk,
  input  logic rst_n,
  input  logic vsync,
  output logic tick
);

  logic vsync_q;

  // Previous vsync level; cleared so a vsync already low at reset release never fires
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vsync_q <= 1'b0;
    else        vsync_q <= vsync;
  end

  assign tick = vsync_q & ~vsync;

endmodule

// File: rtl/death_anim_sequencer.sv
// rtl/death_anim_sequencer.sv - death animation frame sequencer with frame-RAM address generation
module death_anim_sequencer
  import death_anim_pkg::*;
#(
  parameter int                 SPRITE_W   = DEF_SPRITE_W,
  parameter int                 SPRITE_H   = DEF_SPRITE_H,
  parameter int                 NUM_FRAMES = DEF_NUM_FRAMES,
  parameter int                 FRAME_HOLD = DEF_FRAME_HOLD,
  parameter logic [COLOR_W-1:0] KEY_COLOR  = DEF_KEY_COLOR
) (
  input logic                   Clk,
  input logic                   Reset_n,
  death_anim_sequencer_if.slave bus
);

  localparam int FIDX_W  = idx_width(NUM_FRAMES);
  localparam int HOLD_W  = idx_width(FRAME_HOLD);
  localparam int BOUND_W = COORD_W + 1;

  localparam logic [FIDX_W-1:0]  LAST_FRAME = FIDX_W'(NUM_FRAMES - 1);
  localparam logic [HOLD_W-1:0]  LAST_HOLD  = HOLD_W'(FRAME_HOLD - 1);
  localparam logic [ADDR_W-1:0]  FRAME_SIZE = ADDR_W'(SPRITE_W * SPRITE_H);
  localparam logic [ADDR_W-1:0]  ROW_PITCH  = ADDR_W'(SPRITE_W);
  localparam logic [BOUND_W-1:0] W_BOUND    = BOUND_W'(SPRITE_W);
  localparam logic [BOUND_W-1:0] H_BOUND    = BOUND_W'(SPRITE_H);

  state_t             state;
  logic [FIDX_W-1:0]  frame_q;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [COORD_W-1:0] lat_x;
  logic [COORD_W-1:0] lat_y;
  logic               busy_q;
  logic               done_q;

  logic               tick;

  logic [COORD_W-1:0] rx;
  logic [COORD_W-1:0] ry;
  logic               in_box;
  logic               hit;
  logic [ADDR_W-1:0]  addr_next;

  logic [ADDR_W-1:0]  addr_q;
  logic               stage1_q;
  logic               stage2_q;

  vsync_tick u_vsync_tick (
    .clk   (Clk),
    .rst_n (Reset_n),
    .vsync (bus.vsync),
    .tick  (tick)
  );

  // Animation FSM: frame stepping on vsync ticks, busy/done kept as registered outputs
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= IDLE;
      frame_q  <= '0;
      hold_cnt <= '0;
      lat_x    <= '0;
      lat_y    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          // A tick landing on the start cycle is deliberately not counted
          if (bus.start) begin
            state    <= PLAY;
            frame_q  <= '0;
            hold_cnt <= '0;
            lat_x    <= bus.SpriteX;
            lat_y    <= bus.SpriteY;
            busy_q   <= 1'b1;
          end
        end
        PLAY: begin
          if (tick) begin
            if (hold_cnt == LAST_HOLD) begin
              hold_cnt <= '0;
              if (frame_q == LAST_FRAME) begin
                state  <= DONE;
                done_q <= 1'b1;
              end else begin
                frame_q <= frame_q + FIDX_W'(1);
              end
            end else begin
              hold_cnt <= hold_cnt + HOLD_W'(1);
            end
          end
        end
        DONE: begin
          // frame_q intentionally holds the final frame until the next start
          state  <= IDLE;
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  // Sprite-relative coordinates; unsigned wrap is caught by the >= guards
  assign rx = bus.DrawX - lat_x;
  assign ry = bus.DrawY - lat_y;

  assign in_box = (bus.DrawX >= lat_x) && ({1'b0, rx} < W_BOUND) &&
                  (bus.DrawY >= lat_y) && ({1'b0, ry} < H_BOUND);

  assign hit = in_box && busy_q;

  assign addr_next = ADDR_W'(frame_q) * FRAME_SIZE
                   + ADDR_W'(ry) * ROW_PITCH
                   + ADDR_W'(rx);

  // Address register plus two-stage hit pipeline matching the frame RAM read latency
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      addr_q   <= '0;
      stage1_q <= 1'b0;
      stage2_q <= 1'b0;
    end else begin
      addr_q   <= hit ? addr_next : '0;
      stage1_q <= hit;
      stage2_q <= stage1_q;
    end
  end

  assign bus.read_address = addr_q;
  assign bus.sprite_on    = stage2_q && (bus.ram_data != KEY_COLOR);
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.frame_idx    = frame_q;

endmodule
